// File: rtl/seq_fp_multiplier.sv
// Sequential IEEE754 single-precision multiplier: iterative shift-add mantissa
// datapath behind a ready/done handshake, with flush-to-zero and round-to-nearest-even.
module seq_fp_multiplier #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] res,
  output logic        done
);
  localparam int K  = BITS_PER_CYCLE;
  localparam int N  = 24 / K;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    MUL   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t             state_reg;
  logic [31:0]        op1_reg, op2_reg;
  logic [47:0]        mcand_reg, acc_reg;
  logic [23:0]        mult_reg, mant_reg;
  logic [CW-1:0]      cnt_reg;
  logic signed [9:0]  exp_reg;
  logic               sign_reg, guard_reg, sticky_reg;

  logic [7:0]  e1, e2;
  logic        nan1, nan2, inf1, inf2, zero1, zero2, sign_in;
  assign e1      = op1_reg[30:23];
  assign e2      = op2_reg[30:23];
  assign nan1    = (e1 == 8'hFF) && (op1_reg[22:0] != 23'd0);
  assign nan2    = (e2 == 8'hFF) && (op2_reg[22:0] != 23'd0);
  assign inf1    = (e1 == 8'hFF) && (op1_reg[22:0] == 23'd0);
  assign inf2    = (e2 == 8'hFF) && (op2_reg[22:0] == 23'd0);
  // Denormals are flushed, so any zero exponent counts as zero.
  assign zero1   = (e1 == 8'd0);
  assign zero2   = (e2 == 8'd0);
  assign sign_in = op1_reg[31] ^ op2_reg[31];

  // Sum of the multiplicand shifted by each set bit of the current multiplier chunk.
  logic [47:0] partial;
  always_comb begin
    partial = '0;
    for (int i = 0; i < K; i++) begin
      if (mult_reg[i]) partial = partial + (mcand_reg << i);
    end
  end

  logic              round_up;
  logic [24:0]       mant_inc;
  logic [23:0]       mant_fin;
  logic signed [9:0] exp_fin;
  always_comb begin
    round_up = guard_reg & (sticky_reg | mant_reg[0]);
    mant_inc = {1'b0, mant_reg} + {24'd0, round_up};
    mant_fin = mant_inc[23:0];
    exp_fin  = exp_reg;
    if (mant_inc[24]) begin
      mant_fin = 24'h800000;
      exp_fin  = exp_reg + 10'sd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      op1_reg    <= '0;
      op2_reg    <= '0;
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mult_reg   <= '0;
      mant_reg   <= '0;
      cnt_reg    <= '0;
      exp_reg    <= '0;
      sign_reg   <= 1'b0;
      guard_reg  <= 1'b0;
      sticky_reg <= 1'b0;
      res        <= '0;
      done       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (ready) begin
            op1_reg   <= op1;
            op2_reg   <= op2;
            done      <= 1'b0;
            state_reg <= CHECK;
          end
        end
        CHECK: begin
          sign_reg <= sign_in;
          if (nan1 || nan2 || (inf1 && zero2) || (inf2 && zero1)) begin
            res       <= 32'h7FC00000;
            done      <= 1'b1;
            state_reg <= DONE;
          end else if (inf1 || inf2) begin
            res       <= {sign_in, 8'hFF, 23'd0};
            done      <= 1'b1;
            state_reg <= DONE;
          end else if (zero1 || zero2) begin
            res       <= {sign_in, 31'd0};
            done      <= 1'b1;
            state_reg <= DONE;
          end else begin
            mcand_reg <= {24'd0, 1'b1, op1_reg[22:0]};
            mult_reg  <= {1'b1, op2_reg[22:0]};
            acc_reg   <= '0;
            cnt_reg   <= '0;
            exp_reg   <= $signed({2'b00, e1}) + $signed({2'b00, e2}) - 10'sd127;
            state_reg <= MUL;
          end
        end
        MUL: begin
          acc_reg   <= acc_reg + partial;
          mcand_reg <= mcand_reg << K;
          mult_reg  <= mult_reg >> K;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(N - 1)) state_reg <= NORM;
        end
        NORM: begin
          if (acc_reg[47]) begin
            mant_reg   <= acc_reg[47:24];
            guard_reg  <= acc_reg[23];
            sticky_reg <= |acc_reg[22:0];
            exp_reg    <= exp_reg + 10'sd1;
          end else begin
            mant_reg   <= acc_reg[46:23];
            guard_reg  <= acc_reg[22];
            sticky_reg <= |acc_reg[21:0];
          end
          state_reg <= ROUND;
        end
        ROUND: begin
          if (exp_fin >= 10'sd255)   res <= {sign_reg, 8'hFF, 23'd0};
          else if (exp_fin <= 10'sd0) res <= {sign_reg, 31'd0};
          else                        res <= {sign_reg, exp_fin[7:0], mant_fin[22:0]};
          done      <= 1'b1;
          state_reg <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_fp_multiplier.sv
// Self-checking bench for seq_fp_multiplier: directed vector table, handshake/reset
// sequences and randomized operands against an integer-arithmetic reference model.
module tb_seq_fp_multiplier;
  logic        clk;
  logic        rst;
  logic        ready;
  logic [31:0] op1, op2;
  logic [31:0] res;
  logic        done;

  int checks = 0;
  int errors = 0;

  seq_fp_multiplier #(.BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .ready(ready), .op1(op1), .op2(op2), .res(res), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact 48-bit mantissa product, rounding by comparing the discarded
  // remainder against one half ulp.
  task automatic ref_mul(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat);
    logic        s;
    int          ea, eb, e, sh;
    logic        na, nb, ia, ib, za, zb;
    longint unsigned p, m, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    za = (ea == 0);
    zb = (eb == 0);
    lat = 1;
    if (na || nb || (ia && zb) || (ib && za)) begin r = 32'h7FC00000; return; end
    if (ia || ib) begin r = {s, 8'hFF, 23'd0}; return; end
    if (za || zb) begin r = {s, 31'd0}; return; end
    lat = 27;
    p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    e = ea + eb - 127;
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    if (sh == 24) e++;
    m    = p >> sh;
    rem  = p & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && m[0])) m++;
    if (m == (64'd1 << 24)) begin m = 64'd1 << 23; e++; end
    if (e >= 255)     r = {s, 8'hFF, 23'd0};
    else if (e <= 0)  r = {s, 31'd0};
    else              r = {s, 8'(e), m[22:0]};
  endtask

  // Accept one pair, then count edges after acceptance until done (bounded).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int lat);
    @(negedge clk);
    op1 = a; op2 = b; ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    r = res;
  endtask

  initial begin
    logic [31:0] r, er;
    int lat, elat, n;
    logic seen;

    vecs[0]  = '{32'h40400000, 32'h40000000, 32'h40C00000, 27};
    vecs[1]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 27};
    vecs[2]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 27};
    vecs[3]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 27};
    vecs[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1};
    vecs[5]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1};
    vecs[6]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1};
    vecs[7]  = '{32'h00000001, 32'h40000000, 32'h00000000, 1};
    vecs[8]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 27};
    vecs[9]  = '{32'h00800000, 32'h00800000, 32'h00000000, 27};
    vecs[10] = '{32'h80800000, 32'h00800000, 32'h80000000, 27};

    rst = 1'b1; ready = 1'b0; op1 = '0; op2 = '0;
    #2 rst = 1'b0;
    #1;
    check("reset_res", res, 32'h0);
    check("reset_done", {31'd0, done}, 32'd0);
    #10 rst = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (done) seen = 1'b1; end
    check("idle_done_low", {31'd0, seen}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].a, vecs[i].b, r, lat);
      $display("vec %0d: %h x %h -> %h lat %0d", i, vecs[i].a, vecs[i].b, r, lat);
      check($sformatf("vec%0d_res", i), r, vecs[i].r);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    // ready during MUL must be ignored
    @(negedge clk);
    op1 = 32'h40400000; op2 = 32'h40000000; ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ready = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); lat++; @(negedge clk);
      if (lat == 6) begin op1 = 32'h41200000; op2 = 32'h41200000; ready = 1'b1; end
      else ready = 1'b0;
    end
    ready = 1'b0;
    $display("mul_ignore: res %h lat %0d", res, lat);
    check("mul_ignore_res", res, 32'h40C00000);
    check("mul_ignore_lat", 32'(lat), 32'd27);

    // ready in DONE drops done next edge, res holds the old value
    op1 = 32'h40000000; op2 = 32'h40000000; ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ready = 1'b0;
    $display("done_rearm: done %0d res %h", done, res);
    check("rearm_done_low", {31'd0, done}, 32'd0);
    check("rearm_res_hold", res, 32'h40C00000);
    n = 1;
    while (!done && n < 100) begin @(posedge clk); n++; @(negedge clk); end
    check("rearm_new_res", res, 32'h40800000);

    // reset in the middle of MUL
    op1 = 32'h40400000; op2 = 32'h40400000; ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ready = 1'b0;
    repeat (11) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    $display("mid_reset: done %0d res %h", done, res);
    check("midrst_res", res, 32'h0);
    check("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk); rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
    check("midrst_no_done", {31'd0, seen}, 32'd0);

    // randomized operands
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 9))
        0: a[30:23] = 8'hFF;
        1: b[30:23] = 8'h00;
        2: begin a[30:23] = 8'(128 + $urandom_range(0, 126)); b[30:23] = 8'(128 + $urandom_range(0, 126)); end
        3: begin a[30:23] = 8'($urandom_range(1, 64)); b[30:23] = 8'($urandom_range(1, 64)); end
        default: begin a[30:23] = 8'($urandom_range(64, 190)); b[30:23] = 8'($urandom_range(64, 190)); end
      endcase
      ref_mul(a, b, er, elat);
      do_op(a, b, r, lat);
      $display("rand %0d: %h x %h -> %h (model %h) lat %0d", i, a, b, r, er, lat);
      check($sformatf("rand%0d_res", i), r, er);
      check($sformatf("rand%0d_lat", i), 32'(lat), 32'(elat));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
